// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frame parser and command sequencer between the UART byte
// receiver and the EVM control core.
//
// Frame format: SOF, CMD, LEN, PAYLOAD[LEN], CHK where CHK is the XOR of
// CMD, LEN and every payload byte. A validated command is held on a
// valid/ready interface. Length errors, checksum errors, inter-byte
// timeouts and bytes dropped while a command is held are reported as
// one-cycle pulses.
//
// Optional build macro UART_CMD_PARSER_STATS_EN adds the stats_clr input and
// the saturating 16-bit frame_cnt / err_cnt counters.

module uart_cmd_parser #(
    parameter int unsigned MAX_LEN      = 4,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             cmd_code,
    output logic [3:0]             cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_data,
    output logic                   err_chk,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   err_overrun
`ifdef UART_CMD_PARSER_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            err_cnt
`endif
);

    localparam int unsigned TO_W      = $clog2(TIMEOUT_CLKS);
    // Expiry fires on the idle clock that would bring the count to TIMEOUT_CLKS-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 2);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_LEN = 3'd2,
        GET_PAY = 3'd3,
        GET_CHK = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t          state;
    logic [7:0]      chk;
    logic [3:0]      idx;
    logic [TO_W-1:0] to_cnt;

    logic in_frame_c;
    logic expire_c;

    // The timeout only runs while a frame is being assembled.
    assign in_frame_c = (state == GET_CMD) || (state == GET_LEN) ||
                        (state == GET_PAY) || (state == GET_CHK);

    // A byte in the expiry cycle wins over the timeout.
    assign expire_c = in_frame_c && !rx_valid && (to_cnt == TO_LAST);

    // Frame FSM, datapath registers and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            chk         <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_data    <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            // Every byte, every state change and every non-frame state restarts the count.
            if (!in_frame_c || rx_valid || expire_c) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == SOF_BYTE)) begin
                        cmd_data <= '0;
                        chk      <= '0;
                        state    <= GET_CMD;
                    end
                end

                GET_CMD: begin
                    if (rx_valid) begin
                        cmd_code <= rx_data;
                        chk      <= rx_data;
                        state    <= GET_LEN;
                    end
                end

                GET_LEN: begin
                    if (rx_valid) begin
                        if (rx_data > MAX_LEN_B) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cmd_len <= rx_data[3:0];
                            chk     <= chk ^ rx_data;
                            idx     <= '0;
                            if (rx_data == 8'd0) begin
                                state <= GET_CHK;
                            end else begin
                                state <= GET_PAY;
                            end
                        end
                    end
                end

                GET_PAY: begin
                    if (rx_valid) begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            if (idx == 4'(i)) begin
                                cmd_data[8*i +: 8] <= rx_data;
                            end
                        end
                        chk <= chk ^ rx_data;
                        if (idx == (cmd_len - 4'd1)) begin
                            state <= GET_CHK;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end

                GET_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk) begin
                            cmd_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end

                HOLD: begin
                    // The held command is never overwritten; incoming bytes are lost.
                    if (rx_valid) begin
                        err_overrun <= 1'b1;
                    end
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Abandon the frame when the inter-byte gap expires.
            if (expire_c) begin
                err_timeout <= 1'b1;
                state       <= IDLE;
            end
        end
    end

`ifdef UART_CMD_PARSER_STATS_EN
    logic handshake_c;
    logic any_err_c;

    assign handshake_c = cmd_valid && cmd_ready;
    assign any_err_c   = err_chk || err_len || err_timeout || err_overrun;

    // Saturating frame/error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (stats_clr) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (handshake_c && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (any_err_c && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser (MAX_LEN=4, TIMEOUT_CLKS=50).
// Define UART_CMD_PARSER_STATS_EN to also exercise the statistics counters.

module tb_uart_cmd_parser;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned TO_CLKS = 50;
    localparam logic [7:0]  SOF     = 8'hA5;

    logic                 clk;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_code;
    logic [3:0]           cmd_len;
    logic [8*MAX_LEN-1:0] cmd_data;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 err_overrun;
`ifdef UART_CMD_PARSER_STATS_EN
    logic                 stats_clr;
    logic [15:0]          frame_cnt;
    logic [15:0]          err_cnt;
`endif

    uart_cmd_parser #(
        .MAX_LEN      (MAX_LEN),
        .SOF_BYTE     (SOF),
        .TIMEOUT_CLKS (TO_CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
`ifdef UART_CMD_PARSER_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse counters sampled mid-cycle; a one-cycle pulse counts exactly once.
    int n_chk = 0;
    int n_len = 0;
    int n_to  = 0;
    int n_ovr = 0;

    always @(negedge clk) begin
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ovr++;
    end

    typedef struct {
        logic [63:0] bytes;     // byte j at [8j+7:8j], sent first to last
        int          n;
        logic        exp_valid;
        logic [7:0]  code;
        logic [3:0]  len;
        logic [31:0] data;
        int          d_chk;
        int          d_len;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [63:0] bytes, input int n);
        logic [63:0] tmp;
        tmp = bytes;
        for (int j = 0; j < n; j++) begin
            send_byte(tmp[8*j +: 8]);
        end
    endtask

    task automatic handshake(input string name);
        cmd_ready = 1'b1;
        idle(1);
        check({name, "_valid_drop"}, 64'(cmd_valid), 64'd0);
        cmd_ready = 1'b0;
    endtask

    // Frame-level reference: random frame built from the protocol rules, outcome predicted from them.
    task automatic random_frame(input int f);
        logic [7:0]  fr [$];
        logic [7:0]  code;
        logic [7:0]  len;
        logic [7:0]  x;
        logic [7:0]  p;
        logic [31:0] ed;
        int          kind;
        int          nj;
        int          c0;
        int          l0;
        bit          bad;
        bit          exp_v;

        nj = $urandom_range(0, 2);
        for (int i = 0; i < nj; i++) begin
            x = 8'($urandom_range(0, 255));
            if (x == SOF) x = 8'h5A;
            cmd_ready = 1'($urandom_range(0, 1));
            send_byte(x);
            idle($urandom_range(0, 2));
        end
        cmd_ready = 1'b0;
        check("rand_idle_valid", 64'(cmd_valid), 64'd0);

        code = 8'($urandom);
        kind = $urandom_range(0, 9);
        len  = (kind == 0) ? 8'($urandom_range(MAX_LEN + 1, 255)) : 8'($urandom_range(0, MAX_LEN));
        bad  = (kind == 1) || (kind == 2);
        fr.push_back(SOF);
        fr.push_back(code);
        fr.push_back(len);
        ed = '0;
        x  = code ^ len;
        if (len <= 8'(MAX_LEN)) begin
            for (int i = 0; i < int'(len); i++) begin
                p = 8'($urandom);
                fr.push_back(p);
                x ^= p;
                ed[8*i +: 8] = p;
            end
            fr.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        end
        exp_v = (len <= 8'(MAX_LEN)) && !bad;

        c0 = n_chk;
        l0 = n_len;
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (i != fr.size() - 1) idle($urandom_range(0, 4));
        end
        check("rand_valid", 64'(cmd_valid), 64'(exp_v));
        idle(1);
        check("rand_err_chk", 64'(n_chk - c0), 64'((len <= 8'(MAX_LEN)) && bad));
        check("rand_err_len", 64'(n_len - l0), 64'(len > 8'(MAX_LEN)));
        if (exp_v) begin
            check("rand_code", 64'(cmd_code), 64'(code));
            check("rand_len",  64'(cmd_len),  64'(len));
            check("rand_data", 64'(cmd_data), 64'(ed));
            repeat ($urandom_range(0, 3)) begin
                idle(1);
                check("rand_hold_valid", 64'(cmd_valid), 64'd1);
            end
            handshake("rand");
        end
        if (failures != 0 && f == 0) $display("random frame 0 had mismatches");
    endtask

    // Safety net so the run always terminates.
    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, l0, t0, o0, first;
        logic [7:0]  s_code;
        logic [3:0]  s_len;
        logic [31:0] s_data;

        vecs[0] = '{64'h0000_3320_1002_01A5, 6, 1'b1, 8'h01, 4'd2, 32'h0000_2010, 0, 0};
        vecs[1] = '{64'h0000_3420_1002_01A5, 6, 1'b0, 8'h00, 4'd0, 32'h0,         1, 0};
        vecs[2] = '{64'h4344_3322_1104_03A5, 8, 1'b1, 8'h03, 4'd4, 32'h4433_2211, 0, 0};
        vecs[3] = '{64'h0000_0000_0700_07A5, 4, 1'b1, 8'h07, 4'd0, 32'h0,         0, 0};
        vecs[4] = '{64'h0000_3322_1105_07A5, 6, 1'b0, 8'h00, 4'd0, 32'h0,         0, 1};
        vecs[5] = '{64'h00F1_FF01_0FA5_005A, 7, 1'b1, 8'h0F, 4'd1, 32'h0000_00FF, 0, 0};

        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
`ifdef UART_CMD_PARSER_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({cmd_valid, cmd_code, cmd_len, cmd_data, err_chk, err_len, err_timeout, err_overrun}),
              64'd0);
        rst = 1'b0;
        idle(1);

        // Table-driven frames with cmd_ready low so results are held for inspection.
        for (int v = 0; v < 6; v++) begin
            c0 = n_chk;
            l0 = n_len;
            send_frame(vecs[v].bytes, vecs[v].n);
            check($sformatf("vec%0d_valid", v), 64'(cmd_valid), 64'(vecs[v].exp_valid));
            idle(1);
            check($sformatf("vec%0d_err_chk", v), 64'(n_chk - c0), 64'(vecs[v].d_chk));
            check($sformatf("vec%0d_err_len", v), 64'(n_len - l0), 64'(vecs[v].d_len));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_code", v), 64'(cmd_code), 64'(vecs[v].code));
                check($sformatf("vec%0d_len", v),  64'(cmd_len),  64'(vecs[v].len));
                check($sformatf("vec%0d_data", v), 64'(cmd_data), 64'(vecs[v].data));
                handshake($sformatf("vec%0d", v));
            end else begin
                check($sformatf("vec%0d_still_idle", v), 64'(cmd_valid), 64'd0);
            end
        end

        // cmd_ready held high: valid rises one clock after CHK, drops the next.
        cmd_ready = 1'b1;
        idle(2);
        check("ready_idle_ignored", 64'(cmd_valid), 64'd0);
        send_frame(64'h0000_3320_1002_01A5, 6);
        check("ready_high_valid", 64'(cmd_valid), 64'd1);
        check("ready_high_data", 64'(cmd_data), 64'h2010);
        idle(1);
        check("ready_high_drop", 64'(cmd_valid), 64'd0);
        cmd_ready = 1'b0;

        // Timeout fires exactly 49 clocks after the last byte.
        t0 = n_to;
        first = -1;
        send_byte(SOF);
        send_byte(8'h01);
        for (int k = 1; k <= 60; k++) begin
            idle(1);
            if (err_timeout && first < 0) first = k;
        end
        check("timeout_clk", 64'(first), 64'd49);
        check("timeout_pulses", 64'(n_to - t0), 64'd1);

        // A byte exactly in the expiry cycle wins, twice in a row.
        t0 = n_to;
        send_byte(SOF);
        send_byte(8'h01);
        idle(48);
        send_byte(8'h00);
        idle(48);
        send_byte(8'h01);
        check("edge_valid", 64'(cmd_valid), 64'd1);
        check("edge_code", 64'(cmd_code), 64'h01);
        check("edge_len", 64'(cmd_len), 64'd0);
        check("edge_no_timeout", 64'(n_to - t0), 64'd0);
        handshake("edge");

        // Backpressure and overrun, including a byte in the handshake cycle.
        o0 = n_ovr;
        send_frame(64'h4344_3322_1104_03A5, 8);
        s_code = cmd_code;
        s_len  = cmd_len;
        s_data = cmd_data;
        check("bp_valid", 64'(cmd_valid), 64'd1);
        send_byte(8'h55);
        idle(1);
        check("bp_overrun", 64'(n_ovr - o0), 64'd1);
        check("bp_hold_valid", 64'(cmd_valid), 64'd1);
        check("bp_hold_fields", 64'({cmd_code, cmd_len, cmd_data}), 64'({8'h03, 4'd4, 32'h4433_2211}));
        check("bp_hold_stable", 64'({cmd_code, cmd_len, cmd_data}), 64'({s_code, s_len, s_data}));
        cmd_ready = 1'b1;
        send_byte(8'h66);
        cmd_ready = 1'b0;
        check("bp_release", 64'(cmd_valid), 64'd0);
        idle(1);
        check("bp_handshake_overrun", 64'(n_ovr - o0), 64'd2);
        send_byte(8'h66);
        idle(1);
        check("bp_idle_no_overrun", 64'(n_ovr - o0), 64'd2);

        // Reset mid-payload abandons the frame without any pulse.
        c0 = n_chk + n_len + n_to + n_ovr;
        send_frame(64'h0000_0000_1002_01A5, 4);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              64'({cmd_valid, cmd_code, cmd_len, cmd_data, err_chk, err_len, err_timeout, err_overrun}),
              64'd0);
        idle(2);
        rst = 1'b0;
        idle(2);
        send_byte(8'h20);
        send_byte(8'h33);
        check("midrst_tail_dropped", 64'(cmd_valid), 64'd0);
        idle(1);
        check("midrst_no_pulses", 64'(n_chk + n_len + n_to + n_ovr - c0), 64'd0);

        // Randomized frames against the frame-level reference.
        for (int f = 0; f < 150; f++) begin
            random_frame(f);
        end
        check("total_timeouts", 64'(n_to), 64'd1);

`ifdef UART_CMD_PARSER_STATS_EN
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        check("stats_clr_frames", 64'(frame_cnt), 64'd0);
        check("stats_clr_errs", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            send_frame(64'h0000_3320_1002_01A5, 6);
            handshake("stats");
        end
        idle(1);
        check("stats_frames3", 64'(frame_cnt), 64'd3);
        send_frame(64'h0000_3420_1002_01A5, 6);
        idle(2);
        check("stats_err1", 64'(err_cnt), 64'd1);
        send_frame(64'h0000_3320_1002_01A5, 6);
        cmd_ready = 1'b1;
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        cmd_ready = 1'b0;
        check("stats_clr_prio_frames", 64'(frame_cnt), 64'd0);
        check("stats_clr_prio_errs", 64'(err_cnt), 64'd0);
        check("stats_clr_prio_valid", 64'(cmd_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Frame parser and command sequencer between the UART byte receiver and the EVM control core.
- Consumes single-cycle byte strobes and assembles frames of the form SOF, CMD, LEN, PAYLOAD[LEN], CHK.
- Checks length and XOR checksum, and enforces an inter-byte timeout.
- Presents each validated command on a valid/ready interface and reports framing errors as pulses.

Parameters:
- MAX_LEN, 4: maximum payload bytes per frame, 1..15.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CLKS, 100000: idle clocks between bytes before a frame is abandoned (1 ms at 100 MHz); must be at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  single-cycle byte strobe
- cmd_valid  output  1  validated command available
- cmd_ready  input  1  consumer accepts the command
- cmd_code  output  8  command byte
- cmd_len  output  4  payload length
- cmd_data  output  8*MAX_LEN  payload; byte i occupies bits [8i+7:8i]
- err_chk  output  1  checksum mismatch pulse
- err_len  output  1  LEN > MAX_LEN pulse
- err_timeout  output  1  inter-byte timeout pulse
- err_overrun  output  1  byte dropped while holding a command pulse

Behaviour:
- Reset values:
  - All outputs are 0. FSM is in IDLE. Internal checksum, index and timeout counter are 0.
  - Reset asserted mid-frame or mid-hold abandons everything immediately; no error pulse is produced.
- Registers and pulses:
  - All outputs are registered.
  - Each err_* is a one-cycle pulse in the cycle after the offending byte or timeout.
- FSM states: IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK, HOLD. Transitions occur only on rx_valid=1, except HOLD exit and timeout.
- IDLE:
  - rx_data==SOF_BYTE → GET_CMD; cmd_data cleared to 0; checksum cleared.
  - Any other byte is silently dropped.
- GET_CMD:
  - Latch cmd_code; chk = byte → GET_LEN.
- GET_LEN:
  - byte > MAX_LEN → err_len, go to IDLE.
  - Otherwise latch cmd_len; chk ^= byte.
  - If LEN==0 → GET_CHK; else idx=0 → GET_PAY.
- GET_PAY:
  - Store byte at cmd_data[idx]; chk ^= byte.
  - If idx==cmd_len-1 → GET_CHK; else idx++.
- GET_CHK:
  - byte==chk → HOLD; cmd_valid=1 from the next cycle.
  - Mismatch → err_chk, go to IDLE; cmd_valid is never raised.
- HOLD:
  - cmd_valid stays high; cmd_code, cmd_len and cmd_data are stable until handshake.
  - cmd_valid & cmd_ready → cmd_valid=0 next cycle, go to IDLE.
  - Any rx_valid while in HOLD, including the handshake cycle, drops the byte and pulses err_overrun.
- Timeout:
  - Counter runs only in GET_CMD, GET_LEN, GET_PAY and GET_CHK; it clears on every rx_valid and on state entry.
  - Reaching TIMEOUT_CLKS-1 with no byte → err_timeout, go to IDLE.
  - rx_valid arriving in the same cycle as expiry: the byte wins, no timeout.
  - No timeout in IDLE or HOLD.
- Latency: cmd_valid rises 1 clk after the rx_valid carrying CHK.
- cmd_ready asserted while cmd_valid=0 is ignored.
- Widths: idx is 4 bits; chk is 8 bits with XOR wrap; the timeout counter width is $clog2(TIMEOUT_CLKS).

Optional Feature:
- Macro: UART_CMD_PARSER_STATS_EN.
- When defined, the block adds:
  - input stats_clr (1 bit);
  - output frame_cnt (16 bits): increments on each cmd_valid&cmd_ready handshake;
  - output err_cnt (16 bits): increments on any err_* pulse.
- Counter rules:
  - Both counters saturate at 16'hFFFF and reset to 0.
  - stats_clr zeroes both counters synchronously and takes priority over same-cycle increments.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Good frame: A5 01 02 10 20 33, cmd_ready held high → cmd_valid 1 clk after the 33 strobe; cmd_code=01, cmd_len=2, cmd_data=...2010; no errors.
- Bad checksum: A5 01 02 10 20 34 → err_chk one pulse; cmd_valid stays 0; FSM back in IDLE; a following good frame is accepted.
- LEN 0 and length error:
  - A5 07 00 07 → cmd_code=07, cmd_len=0, cmd_data=0.
  - A5 07 05 (MAX_LEN=4) → err_len; subsequent bytes dropped until the next A5.
- Timeout (TIMEOUT_CLKS=50): A5 01, then 60 idle clks → err_timeout at clk 49 after the 01 strobe; a byte arriving exactly at clk 49 instead gives no timeout.
- Backpressure: good frame with cmd_ready=0, then byte 55 strobed in HOLD → err_overrun; outputs unchanged; raising cmd_ready → cmd_valid drops next cycle.
- Reset mid-payload after A5 01 02 10, plus (with UART_CMD_PARSER_STATS_EN) three good frames then stats_clr → all outputs 0 with no pulses; frame_cnt=3 before the clear and 0 after.
